// File: rtl/dvp_pkg.sv
// dvp_pkg: state encoding, RGB565 bar colours and byte-order constant for dvp_tx
package dvp_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} dvp_state_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // index 0 is the leftmost bar
    localparam logic [7:0][15:0] BAR_COLOURS = {
        RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
        RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE
    };

    localparam bit BYTE_HI_FIRST = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

endpackage

// File: rtl/dvp_timing_ctr.sv
// dvp_timing_ctr: h/v position counters with line-wrap and phase-end strobes
module dvp_timing_ctr #(
    parameter int LINE_LEN = 2929,
    parameter int HW       = 13,
    parameter int VW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [VW-1:0] phase_lines,
    output logic [HW-1:0] h_cnt,
    output logic          phase_end
);

    logic [VW-1:0] v_cnt;
    logic          line_end;

    assign line_end  = run && h_cnt == HW'(LINE_LEN - 1);
    assign phase_end = line_end && v_cnt == phase_lines - VW'(1);

    // v_cnt counts lines within the current phase and restarts at each phase end
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= phase_end ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: OV5640-style DVP transmitter serialising RGB565 pixels, high byte first.
// Define DVP_TX_PATTERN_EN to build the internal 8-bar colour generator.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int H_BLANK     = 369,
    parameter int VSYNC_LINES = 5,
    parameter int V_BP        = 14,
    parameter int V_FP        = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        test_pattern,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underrun
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN) + 1;
    localparam int VW       = $clog2(max4(VSYNC_LINES, V_BP, V_ACTIVE, V_FP)) + 1;
    localparam int SLOTS    = 2 * H_ACTIVE;

    dvp_state_t    state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] phase_lines;
    logic          phase_end;
    logic          slot;
    logic          even_slot;
    logic          ur_set;
    logic [15:0]   src;
    logic [7:0]    first_byte;
    logic [7:0]    second_byte;

    assign phase_lines = state == VSYNC  ? VW'(VSYNC_LINES) :
                         state == VBP    ? VW'(V_BP) :
                         state == ACTIVE ? VW'(V_ACTIVE) : VW'(V_FP);

    dvp_timing_ctr #(
        .LINE_LEN(LINE_LEN),
        .HW      (HW),
        .VW      (VW)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .run        (state != IDLE),
        .phase_lines(phase_lines),
        .h_cnt      (h_cnt),
        .phase_end  (phase_end)
    );

    // counter position is one cycle ahead of the registered byte bus
    assign slot      = state == ACTIVE && h_cnt < HW'(SLOTS);
    assign even_slot = slot && !h_cnt[0];

`ifdef DVP_TX_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;

    logic          pattern_on;
    logic          frame_start;
    logic [HW-1:0] bar;
    logic [15:0]   bar_pix;

    assign frame_start = enable && (state == IDLE || (state == VFP && phase_end));
    assign bar         = (h_cnt >> 1) / HW'(BAR_W);
    assign bar_pix     = BAR_COLOURS[bar > HW'(7) ? 3'd7 : bar[2:0]];
    assign pix_ready   = even_slot && !pattern_on;
    assign ur_set      = pix_ready && !pix_valid;
    assign src         = pattern_on ? bar_pix : pix_valid ? pix_data : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst)
            pattern_on <= 1'b0;
        else if (frame_start)
            pattern_on <= test_pattern;
    end
`else
    logic unused_test_pattern;

    assign unused_test_pattern = test_pattern;
    assign pix_ready           = even_slot;
    assign ur_set              = even_slot && !pix_valid;
    assign src                 = pix_valid ? pix_data : 16'h0000;
`endif

    assign first_byte = BYTE_HI_FIRST ? src[15:8] : src[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvp_vsync   <= 1'b0;
            dvp_href    <= 1'b0;
            dvp_data    <= '0;
            second_byte <= '0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            dvp_href   <= slot;
            dvp_data   <= even_slot ? first_byte : slot ? second_byte : 8'h00;
            underrun   <= underrun | ur_set;
            frame_done <= state == VFP && phase_end;
            if (even_slot)
                second_byte <= BYTE_HI_FIRST ? src[7:0] : src[15:8];
            case (state)
                IDLE: if (enable) begin
                    state     <= VSYNC;
                    dvp_vsync <= 1'b1;
                end
                VSYNC: if (phase_end) begin
                    state     <= VBP;
                    dvp_vsync <= 1'b0;
                end
                VBP: if (phase_end)
                    state <= ACTIVE;
                ACTIVE: if (phase_end)
                    state <= VFP;
                VFP: if (phase_end) begin
                    state     <= enable ? VSYNC : IDLE;
                    dvp_vsync <= enable;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
